// File: rtl/greg_mp.sv
// greg_mp: general-register file for the pipelined MIPS core.
//   - NREAD combinational read ports with same-cycle writeback bypass
//   - two synchronous write ports: port 0 = ALU writeback, port 1 = load writeback
//   - per-register busy scoreboard used by decode for RAW hazard stalls
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rd_addr / rd_data   packed read ports, port i at [i*AW +: AW] / [i*DW +: DW]
//   rd_busy             per read port: addressed register has a pending write
//   we0/wa0/wd0         ALU writeback port
//   we1/wa1/wd1         load writeback port (wins a same-address collision)
//   issue_en/issue_reg  decode marks a destination register as pending
//   busy_vec            registered scoreboard, bit r = register r pending
module greg_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*DW-1:0] rd_data,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_reg,
  output logic [(2**AW)-1:0]  busy_vec
);

  localparam int   DEPTH   = 2**AW;
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             we0_eff_s;
  logic             we1_eff_s;
  logic [AW-1:0]    ra_s [NREAD];

  // Writes aimed at the hardwired zero register never reach storage.
  assign we0_eff_s = we0 && !(ZERO_EN && (wa0 == {AW{1'b0}}));
  assign we1_eff_s = we1 && !(ZERO_EN && (wa1 == {AW{1'b0}}));

  assign busy_vec = busy_r;

  // Register storage; port 1 is assigned last so the load wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= {DW{1'b0}};
      end
    end else begin
      if (we0_eff_s) begin
        mem_r[wa0] <= wd0;
      end
      if (we1_eff_s) begin
        mem_r[wa1] <= wd1;
      end
    end
  end

  // Scoreboard next state: a new issue supersedes a completing write to the same register.
  always_comb begin
    busy_nxt_s = {DEPTH{1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      if (ZERO_EN && (r == 0)) begin
        busy_nxt_s[r] = 1'b0;
      end else if (issue_en && (issue_reg == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Scoreboard register; reset drops all pending-write state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports: zero register, then load bypass, then ALU bypass, then storage.
  // A register written this cycle reports not-busy since the bypassed value is valid.
  always_comb begin
    rd_data = {(NREAD*DW){1'b0}};
    rd_busy = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      ra_s[i] = rd_addr[i*AW +: AW];
      if (ZERO_EN && (ra_s[i] == {AW{1'b0}})) begin
        rd_data[i*DW +: DW] = {DW{1'b0}};
        rd_busy[i]          = 1'b0;
      end else if (we1 && (wa1 == ra_s[i])) begin
        rd_data[i*DW +: DW] = wd1;
        rd_busy[i]          = 1'b0;
      end else if (we0 && (wa0 == ra_s[i])) begin
        rd_data[i*DW +: DW] = wd0;
        rd_busy[i]          = 1'b0;
      end else begin
        rd_data[i*DW +: DW] = mem_r[ra_s[i]];
        rd_busy[i]          = busy_r[ra_s[i]];
      end
    end
  end

endmodule

// File: tb/tb_greg_mp.sv
// Testbench for greg_mp: default configuration (DW=32 AW=5 NREAD=2 ZERO_REG=1)
// checked against a behavioural model plus directed values, and a wide
// configuration (DW=64 AW=6 NREAD=4 ZERO_REG=0) checked with directed values.
module tb_greg_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int BDW = 64;
  localparam int BAW = 6;
  localparam int BNR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-configuration DUT signals
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             we0, we1, issue_en;
  logic [AW-1:0]    wa0, wa1, issue_reg;
  logic [DW-1:0]    wd0, wd1;
  logic [31:0]      busy_vec;

  // wide-configuration DUT signals
  logic               b_rst;
  logic [BNR*BAW-1:0] b_rd_addr;
  logic [BNR*BDW-1:0] b_rd_data;
  logic [BNR-1:0]     b_rd_busy;
  logic               b_we0, b_we1, b_issue_en;
  logic [BAW-1:0]     b_wa0, b_wa1, b_issue_reg;
  logic [BDW-1:0]     b_wd0, b_wd1;
  logic [63:0]        b_busy_vec;

  greg_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_reg(issue_reg), .busy_vec(busy_vec)
  );

  greg_mp #(.DW(BDW), .AW(BAW), .NREAD(BNR), .ZERO_REG(0)) u_dut_wide (
    .clk(clk), .rst(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .issue_en(b_issue_en), .issue_reg(b_issue_reg), .busy_vec(b_busy_vec)
  );

  // scoreboard entry: which output to observe and the value it must show
  typedef struct {
    string       tag;
    int          sel;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model of the default configuration
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel, input int port);
    case (sel)
      0:       return 64'(rd_data[port*DW +: DW]);
      1:       return 64'(rd_busy[port]);
      2:       return 64'(busy_vec);
      3:       return b_rd_data[port*BDW +: BDW];
      4:       return 64'(b_rd_busy[port]);
      5:       return b_busy_vec;
      6:       return 64'(busy_vec[port]);
      7:       return 64'(b_busy_vec[port]);
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int port, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel, e.port), e.exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (a == 5'd0)              return 32'd0;
    if (we1 && (wa1 == a))      return wd1;
    if (we0 && (wa0 == a))      return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a);
    if (a == 5'd0)                                   return 1'b0;
    if ((we1 && (wa1 == a)) || (we0 && (wa0 == a)))  return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_clk();
    logic [31:0] nb;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
      m_busy = 32'd0;
    end else begin
      nb = m_busy;
      for (int r = 1; r < 32; r++) begin
        if (issue_en && (issue_reg == 5'(r)))                               nb[r] = 1'b1;
        else if ((we0 && (wa0 == 5'(r))) || (we1 && (wa1 == 5'(r))))        nb[r] = 1'b0;
      end
      nb[0] = 1'b0;
      if (we0 && (wa0 != 5'd0)) m_mem[wa0] = wd0;
      if (we1 && (wa1 != 5'd0)) m_mem[wa1] = wd1;
      m_busy = nb;
    end
  endtask

  // one clock: push model expectations, sample at negedge, advance model at posedge
  task automatic tick();
    logic [AW-1:0] a;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      push($sformatf("rd_data%0d", p), 0, p, 64'(exp_rd(a)));
      push($sformatf("rd_busy%0d", p), 1, p, 64'(exp_rb(a)));
    end
    push("busy_vec", 2, 0, 64'(m_busy));
    @(negedge clk);
    drain();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle_a();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0;
    wd0 = '0; wd1 = '0; issue_en = 1'b0; issue_reg = '0;
    b_rst = 1'b1; b_rd_addr = '0; b_we0 = 1'b0; b_we1 = 1'b0; b_wa0 = '0; b_wa1 = '0;
    b_wd0 = '0; b_wd1 = '0; b_issue_en = 1'b0; b_issue_reg = '0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
    m_busy = 32'd0;
    rst = 1'b0;
    b_rst = 1'b0;

    // T1: fill some registers and mark others busy, then reset with a write pending
    for (int i = 1; i <= 4; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = $urandom;
      issue_en = 1'b1; issue_reg = 5'(i + 10);
      rd_addr = {5'(i + 10), 5'(i)};
      tick();
    end
    rst = 1'b1; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
    tick();
    idle_a();
    rd_addr = {5'd1, 5'd3};
    push("t1_rd0_after_rst", 0, 0, 64'd0);
    push("t1_rd1_after_rst", 0, 1, 64'd0);
    push("t1_busy_after_rst", 2, 0, 64'd0);
    push("t6_busy_after_rst", 5, 0, 64'd0);
    tick();

    // T2: same-cycle bypass, then value from storage
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd5};
    push("t2_bypass", 0, 0, 64'h0000_0000_DEAD_BEEF);
    tick();
    we0 = 1'b0;
    push("t2_stored", 0, 0, 64'h0000_0000_DEAD_BEEF);
    tick();

    // T3: both ports write the same register, load wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2;
    rd_addr = {5'd7, 5'd0};
    push("t3_bypass", 0, 1, 64'd2);
    tick();
    idle_a();
    push("t3_stored", 0, 1, 64'd2);
    tick();

    // T4: register 0 ignores writes and issue
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; issue_en = 1'b1; issue_reg = 5'd0;
    rd_addr = {5'd0, 5'd0};
    push("t4_rd0", 0, 0, 64'd0);
    tick();
    idle_a();
    push("t4_busy0", 6, 0, 64'd0);
    push("t4_rd0_next", 0, 1, 64'd0);
    tick();

    // T5: scoreboard set, clear on writeback, and set-beats-clear
    issue_en = 1'b1; issue_reg = 5'd9; rd_addr = {5'd0, 5'd9};
    tick();
    idle_a();
    push("t5_busy9_set", 6, 9, 64'd1);
    push("t5_rdbusy9", 1, 0, 64'd1);
    tick();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0099;
    push("t5_rdbusy9_wb", 1, 0, 64'd0);
    push("t5_busy9_wb", 6, 9, 64'd1);
    tick();
    idle_a();
    push("t5_busy9_clr", 6, 9, 64'd0);
    issue_en = 1'b1; issue_reg = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0009;
    tick();
    idle_a();
    push("t5_busy9_set_wins", 6, 9, 64'd1);
    push("t5_rdbusy9_again", 1, 0, 64'd1);
    tick();

    // T6: wide configuration, register 0 is ordinary
    b_we0 = 1'b1; b_wa0 = 6'd0; b_wd0 = 64'h0123_4567_89AB_CDEF;
    b_rd_addr = {6'd5, 6'd0, 6'd0, 6'd0};
    push("t6_byp_r0", 3, 2, 64'h0123_4567_89AB_CDEF);
    tick();
    b_we0 = 1'b0; b_issue_en = 1'b1; b_issue_reg = 6'd0;
    push("t6_stored_r0", 3, 2, 64'h0123_4567_89AB_CDEF);
    tick();
    b_issue_en = 1'b0;
    push("t6_busy0_set", 7, 0, 64'd1);
    push("t6_rdbusy_r0", 4, 2, 64'd1);
    tick();
    b_we1 = 1'b1; b_wa1 = 6'd0; b_wd1 = 64'h5;
    push("t6_rdbusy_r0_wb", 4, 2, 64'd0);
    push("t6_byp_ld_r0", 3, 2, 64'h5);
    tick();
    b_we1 = 1'b0;
    push("t6_busy0_clr", 7, 0, 64'd0);
    push("t6_stored_ld_r0", 3, 2, 64'h5);
    b_we0 = 1'b1; b_wa0 = 6'd5; b_wd0 = 64'hDEAD_BEEF_CAFE_F00D;
    push("t6_byp_r5", 3, 3, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    b_we0 = 1'b0;
    push("t6_stored_r5", 3, 3, 64'hDEAD_BEEF_CAFE_F00D);
    tick();

    // random traffic on the default configuration against the model
    for (int n = 0; n < 80; n++) begin
      rst       = ($urandom_range(0, 29) == 0);
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 1));
      issue_en  = 1'($urandom_range(0, 1));
      wa0       = 5'($urandom_range(0, 11));
      wa1       = 5'($urandom_range(0, 11));
      issue_reg = 5'($urandom_range(0, 11));
      wd0       = $urandom;
      wd1       = $urandom;
      rd_addr   = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      tick();
    end
    idle_a();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
